// File: rtl/calc_stack_engine_pkg.sv
// Shared types for the push-button calculator: op codes, error codes,
// FSM states and the operator helpers used by the engine and its ALU.
package calc_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MUL  = 3'd3,
    OP_DIV  = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_OVERFLOW  = 2'd1,
    ERR_DIV0      = 2'd2,
    ERR_MALFORMED = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE_OP,
    REDUCE_ALL,
    RESULT
  } state_e;

  // add/sub bind loosest, mul/div tightest
  function automatic logic prec(input op_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // op button walks 1->2->3->4->1; an empty slot starts at add
  function automatic op_e next_op(input op_e op);
    case (op)
      OP_ADD:  return OP_SUB;
      OP_SUB:  return OP_MUL;
      OP_MUL:  return OP_DIV;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/calc_stack_engine_if.sv
// Button/display bundle between the board inputs and the calculator engine.
interface calc_stack_engine_if #(
  parameter int DATA_W = 8
);
  logic              num_btn;
  logic              op_btn;
  logic              enter_btn;
  logic [DATA_W-1:0] ans;
  logic              result_valid;
  logic              busy;
  logic [1:0]        err;

  modport master (
    output num_btn, op_btn, enter_btn,
    input  ans, result_valid, busy, err
  );

  modport slave (
    input  num_btn, op_btn, enter_btn,
    output ans, result_valid, busy, err
  );
endinterface

// File: rtl/calc_stack_engine_alu.sv
// Combinational ALU: a is second-from-top, b is top of the number stack.
module calc_alu
  import calc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  op_e               op,
  output logic [DATA_W-1:0] y,
  output logic              div0
);

  // all results wrap mod 2^DATA_W; divide by zero saturates to all-ones
  always_comb begin
    y    = '0;
    div0 = 1'b0;
    case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_MUL: y = DATA_W'(a * b);
      OP_DIV: begin
        if (b == '0) begin
          y    = '1;
          div0 = 1'b1;
        end else begin
          y = a / b;
        end
      end
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/calc_stack_engine.sv
// Push-button integer calculator with operator precedence, evaluated on a
// number stack and an operator stack one reduction per clock.
module calc_stack_engine
  import calc_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int HOLDOFF = 100000000
) (
  input logic                 clk,
  input logic                 reset,
  calc_stack_engine_if.slave  bus
);

  localparam int CNT_W = $clog2(HOLDOFF + 1);
  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  holdoff_cnt_q, holdoff_cnt_d;
  logic [DATA_W-1:0] cur_num_q, cur_num_d;
  logic              num_active_q, num_active_d;
  op_e               pending_op_q, pending_op_d;
  logic              result_held_q, result_held_d;
  err_e              err_q, err_d;
  logic [DATA_W-1:0] ans_q, ans_d;
  logic              result_valid_q, result_valid_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] num_stk_q [DEPTH];
  logic [DATA_W-1:0] num_stk_d [DEPTH];
  logic [SP_W-1:0]   num_sp_q, num_sp_d;
  op_e               op_stk_q [DEPTH];
  op_e               op_stk_d [DEPTH];
  logic [SP_W-1:0]   op_sp_q, op_sp_d;

  logic              hold_ready;
  logic              accept;
  logic              do_reduce;
  logic [IDX_W-1:0]  num_top_idx, num_sec_idx, op_top_idx;
  logic [DATA_W-1:0] num_top, num_sec;
  op_e               op_top;
  logic [DATA_W-1:0] alu_y;
  logic              alu_div0;

  assign hold_ready  = (holdoff_cnt_q == CNT_W'(HOLDOFF));
  assign accept      = hold_ready && (state_q == IDLE) &&
                       (!bus.num_btn || !bus.op_btn || !bus.enter_btn);
  assign num_top_idx = IDX_W'(num_sp_q - SP_W'(1));
  assign num_sec_idx = IDX_W'(num_sp_q - SP_W'(2));
  assign op_top_idx  = IDX_W'(op_sp_q - SP_W'(1));
  assign num_top     = num_stk_q[num_top_idx];
  assign num_sec     = num_stk_q[num_sec_idx];
  assign op_top      = op_stk_q[op_top_idx];

  calc_alu #(.DATA_W(DATA_W)) u_alu (
    .a    (num_sec),
    .b    (num_top),
    .op   (op_top),
    .y    (alu_y),
    .div0 (alu_div0)
  );

  // next-state: button events in IDLE, reductions in the reduce states
  always_comb begin
    state_d        = state_q;
    cur_num_d      = cur_num_q;
    num_active_d   = num_active_q;
    pending_op_d   = pending_op_q;
    result_held_d  = result_held_q;
    err_d          = err_q;
    ans_d          = ans_q;
    result_valid_d = 1'b0;
    num_stk_d      = num_stk_q;
    num_sp_d       = num_sp_q;
    op_stk_d       = op_stk_q;
    op_sp_d        = op_sp_q;
    do_reduce      = 1'b0;

    if (accept)          holdoff_cnt_d = '0;
    else if (hold_ready) holdoff_cnt_d = holdoff_cnt_q;
    else                 holdoff_cnt_d = holdoff_cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!bus.num_btn) begin
            if (result_held_q || (num_sp_q == '0 && op_sp_q == '0)) err_d = ERR_NONE;
            if (result_held_q) begin
              num_sp_d      = '0;
              op_sp_d       = '0;
              result_held_d = 1'b0;
              pending_op_d  = OP_NONE;
              cur_num_d     = DATA_W'(1);
              num_active_d  = 1'b1;
              ans_d         = DATA_W'(1);
            end else if (pending_op_q != OP_NONE) begin
              state_d = REDUCE_OP;
            end else begin
              cur_num_d    = cur_num_q + DATA_W'(1);
              num_active_d = 1'b1;
              ans_d        = cur_num_q + DATA_W'(1);
            end
          end else if (!bus.op_btn) begin
            if (num_active_q) begin
              if (num_sp_q == SP_W'(DEPTH)) begin
                if (err_d == ERR_NONE) err_d = ERR_OVERFLOW;
              end else begin
                num_stk_d[IDX_W'(num_sp_q)] = cur_num_q;
                num_sp_d = num_sp_q + SP_W'(1);
              end
              num_active_d = 1'b0;
            end
            result_held_d = 1'b0;
            pending_op_d  = next_op(pending_op_q);
            ans_d         = DATA_W'(next_op(pending_op_q));
          end else begin
            if (pending_op_q != OP_NONE && !num_active_q) begin
              if (err_d == ERR_NONE) err_d = ERR_MALFORMED;
            end else begin
              if (num_active_q) begin
                if (num_sp_q == SP_W'(DEPTH)) begin
                  if (err_d == ERR_NONE) err_d = ERR_OVERFLOW;
                end else begin
                  num_stk_d[IDX_W'(num_sp_q)] = cur_num_q;
                  num_sp_d = num_sp_q + SP_W'(1);
                end
                num_active_d = 1'b0;
              end
              state_d = REDUCE_ALL;
            end
          end
        end
      end

      REDUCE_OP: begin
        if (op_sp_q != '0 && prec(op_top) >= prec(pending_op_q)) begin
          do_reduce = 1'b1;
        end else begin
          if (op_sp_q == SP_W'(DEPTH)) begin
            if (err_d == ERR_NONE) err_d = ERR_OVERFLOW;
          end else begin
            op_stk_d[IDX_W'(op_sp_q)] = pending_op_q;
            op_sp_d = op_sp_q + SP_W'(1);
          end
          pending_op_d = OP_NONE;
          cur_num_d    = DATA_W'(1);
          num_active_d = 1'b1;
          ans_d        = DATA_W'(1);
          state_d      = IDLE;
        end
      end

      // the result is registered on leaving REDUCE_ALL; RESULT is the one
      // cycle the pulse is visible and presses are still locked out
      REDUCE_ALL: begin
        if (op_sp_q != '0) begin
          do_reduce = 1'b1;
        end else if (num_sp_q == '0) begin
          if (err_d == ERR_NONE) err_d = ERR_MALFORMED;
          state_d = IDLE;
        end else begin
          ans_d          = num_top;
          result_valid_d = 1'b1;
          result_held_d  = 1'b1;
          num_stk_d[0]   = num_top;
          num_sp_d       = SP_W'(1);
          state_d        = RESULT;
        end
      end

      RESULT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (do_reduce) begin
      if (num_sp_q < SP_W'(2)) begin
        if (err_d == ERR_NONE) err_d = ERR_MALFORMED;
        num_sp_d      = '0;
        op_sp_d       = '0;
        pending_op_d  = OP_NONE;
        num_active_d  = 1'b0;
        result_held_d = 1'b0;
        state_d       = IDLE;
      end else begin
        num_stk_d[num_sec_idx] = alu_y;
        num_sp_d = num_sp_q - SP_W'(1);
        op_sp_d  = op_sp_q - SP_W'(1);
        if (alu_div0 && err_d == ERR_NONE) err_d = ERR_DIV0;
      end
    end

    busy_d = (state_d == REDUCE_OP) || (state_d == REDUCE_ALL);
  end

  // state and registered outputs; reset aborts any reduction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      holdoff_cnt_q  <= '0;
      cur_num_q      <= '0;
      num_active_q   <= 1'b0;
      pending_op_q   <= OP_NONE;
      result_held_q  <= 1'b0;
      err_q          <= ERR_NONE;
      ans_q          <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      num_sp_q       <= '0;
      op_sp_q        <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        num_stk_q[i] <= '0;
        op_stk_q[i]  <= OP_NONE;
      end
    end else begin
      state_q        <= state_d;
      holdoff_cnt_q  <= holdoff_cnt_d;
      cur_num_q      <= cur_num_d;
      num_active_q   <= num_active_d;
      pending_op_q   <= pending_op_d;
      result_held_q  <= result_held_d;
      err_q          <= err_d;
      ans_q          <= ans_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      num_sp_q       <= num_sp_d;
      op_sp_q        <= op_sp_d;
      num_stk_q      <= num_stk_d;
      op_stk_q       <= op_stk_d;
    end
  end

  assign bus.ans          = ans_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_calc_stack_engine.sv
// Directed bench for calc_stack_engine: an 8-bit/16-deep unit and a
// 4-bit/2-deep unit, both with a 4-clock hold-off.
module tb_calc_stack_engine;

  localparam int WIN = 12;
  localparam int NUM = 0;
  localparam int OP  = 1;
  localparam int ENT = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  calc_stack_engine_if #(.DATA_W(8)) bus8 ();
  calc_stack_engine_if #(.DATA_W(4)) bus4 ();

  calc_stack_engine #(.DATA_W(8), .DEPTH(16), .HOLDOFF(4)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  calc_stack_engine #(.DATA_W(4), .DEPTH(2), .HOLDOFF(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input bit u4, input int btn, input logic v);
    if (u4) begin
      case (btn)
        NUM:     bus4.num_btn   = v;
        OP:      bus4.op_btn    = v;
        default: bus4.enter_btn = v;
      endcase
    end else begin
      case (btn)
        NUM:     bus8.num_btn   = v;
        OP:      bus8.op_btn    = v;
        default: bus8.enter_btn = v;
      endcase
    end
  endtask

  // one-clock press, then a fixed window counting busy and result_valid
  task automatic press(input bit u4, input int btn, output int nb, output int nr);
    nb = 0;
    nr = 0;
    @(negedge clk);
    drive(u4, btn, 1'b0);
    for (int i = 0; i < WIN; i++) begin
      @(negedge clk);
      if (i == 0) drive(u4, btn, 1'b1);
      if (u4) begin
        nb += int'(bus4.busy);
        nr += int'(bus4.result_valid);
      end else begin
        nb += int'(bus8.busy);
        nr += int'(bus8.result_valid);
      end
    end
  endtask

  task automatic press_n(input bit u4, input int btn, input int n);
    int nb, nr;
    for (int k = 0; k < n; k++) press(u4, btn, nb, nr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int nb, nr;
    reset = 1'b1;
    bus8.num_btn = 1'b1; bus8.op_btn = 1'b1; bus8.enter_btn = 1'b1;
    bus4.num_btn = 1'b1; bus4.op_btn = 1'b1; bus4.enter_btn = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ans",  bus8.ans, 0);
    check("rst_rv",   bus8.result_valid, 0);
    check("rst_busy", bus8.busy, 0);
    check("rst_err",  bus8.err, 0);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // held button repeats every HOLDOFF+1 clocks
    bus8.num_btn = 1'b0;
    repeat (20) @(negedge clk);
    bus8.num_btn = 1'b1;
    repeat (6) @(negedge clk);
    check("held_ans", bus8.ans, 4);

    // 2 + 3 * 4 = 14
    do_reset();
    press_n(0, NUM, 2);
    press(0, OP, nb, nr);
    check("op_add_ans", bus8.ans, 1);
    press(0, NUM, nb, nr);
    press_n(0, NUM, 2);
    press_n(0, OP, 3);
    check("op_mul_ans", bus8.ans, 3);
    press(0, NUM, nb, nr);
    check("no_early_reduce_busy", nb, 1);
    press_n(0, NUM, 3);
    check("num4_ans", bus8.ans, 4);
    press(0, ENT, nb, nr);
    check("prec_ans", bus8.ans, 14);
    check("prec_rv_pulses", nr, 1);
    check("prec_busy", nb, 3);
    check("prec_err", bus8.err, 0);

    // chain: 14 + 1 = 15, then a fresh number
    press(0, OP, nb, nr);
    press(0, NUM, nb, nr);
    press(0, ENT, nb, nr);
    check("chain_ans", bus8.ans, 15);
    check("chain_rv", nr, 1);
    press(0, NUM, nb, nr);
    check("fresh_ans", bus8.ans, 1);
    check("fresh_err", bus8.err, 0);

    // operator followed directly by enter is malformed
    press(0, OP, nb, nr);
    press(0, ENT, nb, nr);
    check("malformed_err", bus8.err, 3);
    check("malformed_rv", nr, 0);

    // 2 * 3 + 4 = 10 with an early reduction
    do_reset();
    press_n(0, NUM, 2);
    press_n(0, OP, 3);
    press_n(0, NUM, 3);
    press(0, OP, nb, nr);
    press(0, NUM, nb, nr);
    check("early_reduce_busy", nb, 2);
    check("early_reduce_ans", bus8.ans, 1);
    press_n(0, NUM, 3);
    press(0, ENT, nb, nr);
    check("mul_first_ans", bus8.ans, 10);

    // 4-bit: 6 / 0 -> all ones with divide-by-zero
    press_n(1, NUM, 6);
    press_n(1, OP, 4);
    check("div_op_ans", bus4.ans, 4);
    press_n(1, NUM, 16);
    check("wrap_ans", bus4.ans, 0);
    press(1, ENT, nb, nr);
    check("div0_ans", bus4.ans, 15);
    check("div0_err", bus4.err, 2);
    check("div0_rv", nr, 1);

    // 2-deep: 1 + 2 * 3 overflows the number stack
    press(1, NUM, nb, nr);
    check("restart_err", bus4.err, 0);
    press(1, OP, nb, nr);
    press_n(1, NUM, 2);
    press_n(1, OP, 3);
    press_n(1, NUM, 3);
    press(1, ENT, nb, nr);
    check("ovf_err", bus4.err, 1);
    check("ovf_rv", nr, 0);

    // reset mid-evaluation
    do_reset();
    press_n(0, NUM, 2);
    press(0, OP, nb, nr);
    press_n(0, NUM, 3);
    press_n(0, OP, 3);
    press_n(0, NUM, 4);
    @(negedge clk);
    bus8.enter_btn = 1'b0;
    @(posedge clk);
    #1;
    bus8.enter_btn = 1'b1;
    check("mid_busy", bus8.busy, 1);
    reset = 1'b1;
    #1;
    check("abort_ans",  bus8.ans, 0);
    check("abort_busy", bus8.busy, 0);
    check("abort_rv",   bus8.result_valid, 0);
    check("abort_err",  bus8.err, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    press(0, NUM, nb, nr);
    check("post_abort_ans", bus8.ans, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
